// File: rtl/encout_mch_pkg.sv
// -----------------------------------------------------------------------------
// encout_mch_pkg
// Shared definitions for the multi-channel quadrature encoder-output generator:
//   - per-channel register byte offsets and their word indices
//   - CTL / STAT bit positions
//   - channel FSM state enum
//   - quadrature phase sequencing helper
// Optional feature macro used by the design: ENCOUT_MCH_ELC_EN (event-link start).
// -----------------------------------------------------------------------------
package encout_mch_pkg;

  // Byte offsets inside one channel's 0x20-byte window.
  localparam logic [4:0] REG_CTL    = 5'h00;
  localparam logic [4:0] REG_STAT   = 5'h04;
  localparam logic [4:0] REG_PERIOD = 5'h08;
  localparam logic [4:0] REG_POSMAX = 5'h0C;
  localparam logic [4:0] REG_OUTCNT = 5'h10;
  localparam logic [4:0] REG_POSCNT = 5'h14;

  // Word indices (PADDR[4:2]) used by the decoder and the channel read mux.
  localparam logic [2:0] IDX_CTL    = REG_CTL[4:2];
  localparam logic [2:0] IDX_STAT   = REG_STAT[4:2];
  localparam logic [2:0] IDX_PERIOD = REG_PERIOD[4:2];
  localparam logic [2:0] IDX_POSMAX = REG_POSMAX[4:2];
  localparam logic [2:0] IDX_OUTCNT = REG_OUTCNT[4:2];
  localparam logic [2:0] IDX_POSCNT = REG_POSCNT[4:2];

  // CTL bits
  localparam int CTL_START = 0;
  localparam int CTL_STOP  = 1;
  localparam int CTL_DIR   = 2;
  localparam int CTL_IE    = 3;
  localparam int CTL_ELCEN = 4;

  // STAT bits
  localparam int STAT_RUN  = 0;
  localparam int STAT_DONE = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_e;

  // Phase is {A,B}. Forward walks 00->10->11->01->00, reverse walks it backwards.
  function automatic logic [1:0] next_phase(input logic [1:0] ph, input logic rev);
    logic [1:0] r;
    if (!rev) begin
      case (ph)
        2'b00:   r = 2'b10;
        2'b10:   r = 2'b11;
        2'b11:   r = 2'b01;
        default: r = 2'b00;
      endcase
    end else begin
      case (ph)
        2'b00:   r = 2'b01;
        2'b01:   r = 2'b11;
        2'b11:   r = 2'b10;
        default: r = 2'b00;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/encout_mch_ch.sv
// -----------------------------------------------------------------------------
// encout_mch_ch
// One encoder-output channel: register file, IDLE/RUN FSM, period timer,
// remaining-step counter, position counter and quadrature phase.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   elc_i                event start input (asynchronous; used only when
//                        ENCOUT_MCH_ELC_EN is defined)
//   wr_en_i              qualified, error-free write to this channel
//   off_i                register word index (read and write)
//   wdata_i              write data (low CW bits)
//   rdata_o              zero-extended read value of register off_i
//   run_o                channel is in RUN
//   irq_o                DONE & IE
//   pouta_o/poutb_o/poutz_o registered quadrature and index outputs
// Macro: ENCOUT_MCH_ELC_EN adds a 2-FF synchroniser + rising-edge detect on
// elc_i and makes CTL.ELCEN writable.
// -----------------------------------------------------------------------------
module encout_mch_ch
  import encout_mch_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          elc_i,
  input  logic          wr_en_i,
  input  logic [2:0]    off_i,
  input  logic [CW-1:0] wdata_i,
  output logic [31:0]   rdata_o,
  output logic          run_o,
  output logic          irq_o,
  output logic          pouta_o,
  output logic          poutb_o,
  output logic          poutz_o
);

  ch_state_e     state_q, state_d;
  logic          dir_q, dir_d;
  logic          ie_q, ie_d;
  logic          done_q, done_d;
  logic [CW-1:0] period_q, period_d;
  logic [CW-1:0] posmax_q, posmax_d;
  logic [CW-1:0] outcnt_q, outcnt_d;
  logic [CW-1:0] poscnt_q, poscnt_d;
  logic [CW-1:0] per_act_q, per_act_d;   // period in force for the current step
  logic [CW-1:0] per_cnt_q, per_cnt_d;
  logic [CW-1:0] rem_q, rem_d;           // steps left; 0 = continuous
  logic [1:0]    phase_q, phase_d;
  logic          z_q, z_d;

  logic wr_ctl, wr_stat, wr_period, wr_posmax, wr_outcnt, wr_poscnt;
  logic start_req, stop_req, running, step, last_step;
  logic elcen, elc_start;

`ifdef ENCOUT_MCH_ELC_EN
  // [0],[1] synchroniser stages, [2] previous synchronised value for edge detect
  logic [2:0] elc_sync_q;
  logic       elcen_q, elcen_d;

  always_comb begin
    elcen_d = elcen_q;
    if (wr_ctl) elcen_d = wdata_i[CTL_ELCEN];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      elc_sync_q <= '0;
      elcen_q    <= 1'b0;
    end else begin
      elc_sync_q <= {elc_sync_q[1:0], elc_i};
      elcen_q    <= elcen_d;
    end
  end

  assign elcen     = elcen_q;
  assign elc_start = elcen_q & elc_sync_q[1] & ~elc_sync_q[2];
`else
  logic unused_elc;
  assign unused_elc = elc_i;
  assign elcen      = 1'b0;
  assign elc_start  = 1'b0;
`endif

  always_comb begin
    wr_ctl    = wr_en_i && (off_i == IDX_CTL);
    wr_stat   = wr_en_i && (off_i == IDX_STAT);
    wr_period = wr_en_i && (off_i == IDX_PERIOD);
    wr_posmax = wr_en_i && (off_i == IDX_POSMAX);
    wr_outcnt = wr_en_i && (off_i == IDX_OUTCNT);
    wr_poscnt = wr_en_i && (off_i == IDX_POSCNT);

    start_req = (wr_ctl && wdata_i[CTL_START]) || elc_start;
    stop_req  = wr_ctl && wdata_i[CTL_STOP];
    running   = (state_q == ST_RUN);
    step      = running && (per_cnt_q == per_act_q);
    last_step = step && (rem_q == CW'(1));

    state_d   = state_q;
    dir_d     = dir_q;
    ie_d      = ie_q;
    period_d  = period_q;
    posmax_d  = posmax_q;
    outcnt_d  = outcnt_q;
    poscnt_d  = poscnt_q;
    per_act_d = per_act_q;
    per_cnt_d = per_cnt_q;
    rem_d     = rem_q;
    phase_d   = phase_q;

    if (wr_ctl) begin
      dir_d = wdata_i[CTL_DIR];
      ie_d  = wdata_i[CTL_IE];
    end
    if (wr_period) period_d = wdata_i;
    if (wr_posmax) posmax_d = wdata_i;
    if (wr_outcnt) outcnt_d = wdata_i;
    // The decoder already rejects POSCNT writes during RUN; guard locally too.
    if (wr_poscnt && !running) poscnt_d = wdata_i;

    if (!running) begin
      if (start_req && !stop_req) begin
        state_d   = ST_RUN;
        per_cnt_d = '0;
        per_act_d = period_q;
        rem_d     = outcnt_q;
      end
    end else begin
      if (step) begin
        // New PERIOD/POSMAX/DIR values are picked up here, at the step boundary.
        per_cnt_d = '0;
        per_act_d = period_q;
        phase_d   = next_phase(phase_q, dir_q);
        if (!dir_q) poscnt_d = (poscnt_q == posmax_q) ? '0 : poscnt_q + CW'(1);
        else        poscnt_d = (poscnt_q == '0) ? posmax_q : poscnt_q - CW'(1);
        if (rem_q != '0) rem_d = rem_q - CW'(1);
      end else begin
        per_cnt_d = per_cnt_q + CW'(1);
      end
      if (stop_req || last_step) state_d = ST_IDLE;
    end

    // Setting DONE takes priority over a simultaneous write-1-clear.
    done_d = done_q;
    if (wr_stat && wdata_i[STAT_DONE]) done_d = 1'b0;
    if (last_step) done_d = 1'b1;

    z_d = (poscnt_d == '0) && (phase_d == 2'b00);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      dir_q     <= 1'b0;
      ie_q      <= 1'b0;
      done_q    <= 1'b0;
      period_q  <= '0;
      posmax_q  <= '0;
      outcnt_q  <= '0;
      poscnt_q  <= '0;
      per_act_q <= '0;
      per_cnt_q <= '0;
      rem_q     <= '0;
      phase_q   <= 2'b00;
      z_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      ie_q      <= ie_d;
      done_q    <= done_d;
      period_q  <= period_d;
      posmax_q  <= posmax_d;
      outcnt_q  <= outcnt_d;
      poscnt_q  <= poscnt_d;
      per_act_q <= per_act_d;
      per_cnt_q <= per_cnt_d;
      rem_q     <= rem_d;
      phase_q   <= phase_d;
      z_q       <= z_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    case (off_i)
      IDX_CTL:    rdata_o = 32'({elcen, ie_q, dir_q, 2'b00});
      IDX_STAT:   rdata_o = 32'({done_q, running});
      IDX_PERIOD: rdata_o = 32'(period_q);
      IDX_POSMAX: rdata_o = 32'(posmax_q);
      IDX_OUTCNT: rdata_o = 32'(outcnt_q);
      IDX_POSCNT: rdata_o = 32'(poscnt_q);
      default:    rdata_o = '0;
    endcase
  end

  assign run_o   = running;
  assign irq_o   = done_q & ie_q;
  assign pouta_o = phase_q[1];
  assign poutb_o = phase_q[0];
  assign poutz_o = z_q;

endmodule

// File: rtl/encout_mch_gen.sv
// -----------------------------------------------------------------------------
// encout_mch_gen
// Multi-channel quadrature encoder-output generator with an APB3 slave.
// Channel c occupies byte window c*0x20; see encout_mch_pkg for offsets.
// Ports:
//   PCLK, PRESETN                   clock, asynchronous active-low reset
//   PADDR/PSEL/PENABLE/PWRITE/PWDATA APB3 request
//   PRDATA/PREADY/PSLVERR           APB3 response (zero wait states)
//   ELC_IN[NCH]                     per-channel event start (asynchronous)
//   POUTA/POUTB/POUTZ[NCH]          registered quadrature and index outputs
//   IRQ                             registered OR of DONE & IE over channels
// Macro: ENCOUT_MCH_ELC_EN enables the ELC_IN start path in each channel.
// -----------------------------------------------------------------------------
module encout_mch_gen
  import encout_mch_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = 16
) (
  input  logic           PCLK,
  input  logic           PRESETN,
  input  logic [31:0]    PADDR,
  input  logic           PSEL,
  input  logic           PENABLE,
  input  logic           PWRITE,
  input  logic [31:0]    PWDATA,
  output logic [31:0]    PRDATA,
  output logic           PREADY,
  output logic           PSLVERR,
  input  logic [NCH-1:0] ELC_IN,
  output logic [NCH-1:0] POUTA,
  output logic [NCH-1:0] POUTB,
  output logic [NCH-1:0] POUTZ,
  output logic           IRQ
);

  logic [31:0]    ch_rdata [NCH];
  logic [NCH-1:0] run_vec;
  logic [NCH-1:0] irq_vec;
  logic [NCH-1:0] ch_wr;

  logic [2:0]  ch_idx;
  logic [2:0]  off_idx;
  logic        ch_in_range, off_ok, poscnt_busy, addr_err, access, wr_ok;
  logic [31:0] rd_sel;
  logic        run_sel;
  logic        irq_q;

  // Byte lanes and unused PWDATA bits carry no information for this block.
  logic unused_bits;
  assign unused_bits = ^{PADDR[1:0], PWDATA};

  assign ch_idx      = PADDR[7:5];
  assign off_idx     = PADDR[4:2];
  // Compare the full upper address so aliases above the last channel error out.
  assign ch_in_range = (PADDR[31:5] < 27'(NCH));
  assign off_ok      = (off_idx <= IDX_POSCNT);

  always_comb begin
    rd_sel  = '0;
    run_sel = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_idx == 3'(i)) begin
        rd_sel  = ch_rdata[i];
        run_sel = run_vec[i];
      end
    end
  end

  assign poscnt_busy = PWRITE && (off_idx == IDX_POSCNT) && run_sel;
  assign addr_err    = !ch_in_range || !off_ok || poscnt_busy;
  assign access      = PSEL && PENABLE;
  assign wr_ok       = access && PWRITE && !addr_err;

  assign PREADY  = 1'b1;
  assign PSLVERR = access && addr_err;
  assign PRDATA  = (PSEL && !PWRITE && !addr_err) ? rd_sel : '0;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    assign ch_wr[gi] = wr_ok && (ch_idx == 3'(gi));

    encout_mch_ch #(
      .CW (CW)
    ) u_ch (
      .clk_i   (PCLK),
      .rst_ni  (PRESETN),
      .elc_i   (ELC_IN[gi]),
      .wr_en_i (ch_wr[gi]),
      .off_i   (off_idx),
      .wdata_i (PWDATA[CW-1:0]),
      .rdata_o (ch_rdata[gi]),
      .run_o   (run_vec[gi]),
      .irq_o   (irq_vec[gi]),
      .pouta_o (POUTA[gi]),
      .poutb_o (POUTB[gi]),
      .poutz_o (POUTZ[gi])
    );
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) irq_q <= 1'b0;
    else          irq_q <= |irq_vec;
  end

  assign IRQ = irq_q;

endmodule

// File: tb/tb_encout_mch_gen.sv
// -----------------------------------------------------------------------------
// tb_encout_mch_gen
// Directed bench for encout_mch_gen (NCH=4, CW=16): a table of register
// accesses followed by hand-written multi-cycle sequences.
// Honours ENCOUT_MCH_ELC_EN for the ELCEN / ELC_IN expectations.
// -----------------------------------------------------------------------------
module tb_encout_mch_gen;

  localparam int NCH = 4;
  localparam int CW  = 16;

`ifdef ENCOUT_MCH_ELC_EN
  localparam logic [31:0] CTL_RB   = 32'h1C;
  localparam logic [31:0] ELCEN_RB = 32'h10;
  localparam logic [31:0] ELC_RUN  = 32'h1;
`else
  localparam logic [31:0] CTL_RB   = 32'h0C;
  localparam logic [31:0] ELCEN_RB = 32'h00;
  localparam logic [31:0] ELC_RUN  = 32'h0;
`endif

  logic           clk = 1'b0;
  logic           PRESETN;
  logic [31:0]    PADDR;
  logic           PSEL, PENABLE, PWRITE;
  logic [31:0]    PWDATA;
  logic [31:0]    PRDATA;
  logic           PREADY, PSLVERR;
  logic [NCH-1:0] ELC_IN;
  logic [NCH-1:0] POUTA, POUTB, POUTZ;
  logic           IRQ;

  always #5 clk = ~clk;

  encout_mch_gen #(.NCH(NCH), .CW(CW)) dut (
    .PCLK    (clk),
    .PRESETN (PRESETN),
    .PADDR   (PADDR),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .ELC_IN  (ELC_IN),
    .POUTA   (POUTA),
    .POUTB   (POUTB),
    .POUTZ   (POUTZ),
    .IRQ     (IRQ)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    string       name;
  } vec_t;

  vec_t vq[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Phase order {A,B} written out by hand.
  logic [1:0] seq_ab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", nm, act);
    end
  endtask

  task automatic add(input logic wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] er, input logic ee, input string nm);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = d; v.exp_rd = er; v.exp_err = ee; v.name = nm;
    vq.push_back(v);
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d, output logic err);
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    @(negedge clk);
    err = PSLVERR;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic err);
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    @(negedge clk);
    d = PRDATA; err = PSLVERR;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    logic        err;
    logic [31:0] rd;
    logic [1:0]  ph;
    int          idx, pos, changes;
    logic [1:0]  prev;

    PRESETN = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; ELC_IN = '0;

    // Register-access table (channel 0 unless stated)
    add(0, 32'h00, 0, 32'h0, 0, "rst_ctl");
    add(0, 32'h04, 0, 32'h0, 0, "rst_stat");
    add(0, 32'h14, 0, 32'h0, 0, "rst_poscnt");
    add(1, 32'h08, 3, 0, 0, "wr_period");
    add(0, 32'h08, 0, 32'h3, 0, "rd_period");
    add(1, 32'h0C, 7, 0, 0, "wr_posmax");
    add(0, 32'h0F, 0, 32'h7, 0, "rd_posmax_lowbits");
    add(1, 32'h00, 32'h1C, 0, 0, "wr_ctl");
    add(0, 32'h00, 0, CTL_RB, 0, "rd_ctl");
    add(1, 32'h00, 32'h00, 0, 0, "wr_ctl_clr");
    add(0, 32'h18, 0, 32'h0, 1, "rd_unmapped");
    add(1, 32'h18, 32'h55, 0, 1, "wr_unmapped");
    add(0, 32'hA0, 0, 32'h0, 1, "rd_ch5");
    add(1, 32'hA8, 32'h9, 0, 1, "wr_ch5");
    add(1, 32'h28, 32'h1ABCD, 0, 0, "wr_ch1_period");
    add(0, 32'h28, 0, 32'hABCD, 0, "rd_ch1_period_trunc");
    add(0, 32'h10, 0, 32'h0, 0, "rd_outcnt");

    repeat (2) @(posedge clk);
    #1;
    chk("rst_pouta", 32'(POUTA), 32'h0);
    chk("rst_poutb", 32'(POUTB), 32'h0);
    chk("rst_poutz", 32'(POUTZ), 32'h0);
    chk("rst_irq", 32'(IRQ), 32'h0);
    chk("rst_prdata", PRDATA, 32'h0);
    PRESETN = 1'b1;
    @(posedge clk); #1;
    chk("z_after_release", 32'(POUTZ), 32'hF);
    chk("pready", 32'(PREADY), 32'h1);

    foreach (vq[i]) begin
      if (vq[i].wr) begin
        apb_write(vq[i].addr, vq[i].wdata, err);
        chk({vq[i].name, "_err"}, 32'(err), 32'(vq[i].exp_err));
      end else begin
        apb_read(vq[i].addr, rd, err);
        chk(vq[i].name, rd, vq[i].exp_rd);
        chk({vq[i].name, "_err"}, 32'(err), 32'(vq[i].exp_err));
      end
    end

    // ch0 forward, PERIOD=3, POSMAX=7, continuous
    apb_write(32'h10, 32'h0, err);
    apb_write(32'h00, 32'h1, err);
    idx = 0; pos = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k % 4 == 0) begin
        idx = (idx + 1) % 4;
        pos = (pos == 7) ? 0 : pos + 1;
      end
      ph = seq_ab[idx];
      chk($sformatf("ch0_ab_k%0d", k), 32'({POUTA[0], POUTB[0]}), 32'(ph));
      chk($sformatf("ch0_z_k%0d", k), 32'(POUTZ[0]), 32'((pos == 0) && (ph == 2'b00)));
    end
    apb_write(32'h00, 32'h2, err);
    apb_read(32'h14, rd, err);
    chk("ch0_poscnt_after_stop", rd, 32'd2);
    apb_read(32'h04, rd, err);
    chk("ch0_stat_after_stop", rd, 32'h0);
    repeat (6) @(posedge clk);
    #1;
    chk("ch0_phase_held", 32'({POUTA[0], POUTB[0]}), 32'h3);

    // ch1 OUTCNT=5, PERIOD=1, IE
    apb_write(32'h2C, 32'd15, err);
    apb_write(32'h30, 32'd5, err);
    apb_write(32'h28, 32'd1, err);
    apb_write(32'h20, 32'h9, err);
    prev = {POUTA[1], POUTB[1]};
    changes = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if ({POUTA[1], POUTB[1]} != prev) changes++;
      prev = {POUTA[1], POUTB[1]};
    end
    chk("ch1_step_count", 32'(changes), 32'd5);
    chk("ch1_final_phase", 32'({POUTA[1], POUTB[1]}), 32'h2);
    apb_read(32'h24, rd, err);
    chk("ch1_stat_done", rd, 32'h2);
    chk("ch1_irq_set", 32'(IRQ), 32'h1);
    apb_read(32'h34, rd, err);
    chk("ch1_poscnt", rd, 32'd5);
    apb_write(32'h24, 32'h2, err);
    apb_read(32'h24, rd, err);
    chk("ch1_stat_cleared", rd, 32'h0);
    chk("ch1_irq_cleared", 32'(IRQ), 32'h0);

    // ch2 reverse, PERIOD=0, POSMAX=9, three steps
    apb_write(32'h4C, 32'd9, err);
    apb_write(32'h54, 32'd0, err);
    chk("ch2_poscnt_wr_idle_err", 32'(err), 32'h0);
    apb_write(32'h48, 32'd0, err);
    apb_write(32'h50, 32'd3, err);
    chk("ch2_z_before", 32'(POUTZ[2]), 32'h1);
    apb_write(32'h40, 32'h5, err);
    idx = 0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      idx = (idx + 3) % 4;
      chk($sformatf("ch2_ab_k%0d", k), 32'({POUTA[2], POUTB[2]}), 32'(seq_ab[idx]));
      chk($sformatf("ch2_z_k%0d", k), 32'(POUTZ[2]), 32'h0);
    end
    apb_read(32'h54, rd, err);
    chk("ch2_poscnt", rd, 32'd7);
    apb_read(32'h44, rd, err);
    chk("ch2_stat_done", rd, 32'h2);
    chk("ch2_irq_masked", 32'(IRQ), 32'h0);

    // START and STOP together stay IDLE
    apb_write(32'h40, 32'h3, err);
    apb_read(32'h44, rd, err);
    chk("ch2_start_stop_idle", rd, 32'h2);

    // ch3 event start
    apb_write(32'h60, 32'h10, err);
    apb_read(32'h60, rd, err);
    chk("ch3_elcen_rb", rd, ELCEN_RB);
    ELC_IN[3] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    apb_read(32'h64, rd, err);
    chk("ch3_elc_run", rd, ELC_RUN);
    ELC_IN[3] = 1'b0;
    apb_write(32'h60, 32'h2, err);

    // POSCNT write while running is rejected
    apb_write(32'h68, 32'd100, err);
    apb_write(32'h74, 32'd3, err);
    chk("ch3_poscnt_wr_idle_err", 32'(err), 32'h0);
    apb_write(32'h60, 32'h1, err);
    apb_write(32'h74, 32'd5, err);
    chk("ch3_poscnt_wr_run_err", 32'(err), 32'h1);
    apb_read(32'h74, rd, err);
    chk("ch3_poscnt_unchanged", rd, 32'd3);
    apb_read(32'h64, rd, err);
    chk("ch3_running", rd, 32'h1);

    // Reset mid-run
    apb_write(32'h40, 32'h8, err);
    @(posedge clk); #1;
    chk("irq_before_reset", 32'(IRQ), 32'h1);
    PRESETN = 1'b0;
    #2;
    chk("midrst_pouta", 32'(POUTA), 32'h0);
    chk("midrst_poutb", 32'(POUTB), 32'h0);
    chk("midrst_poutz", 32'(POUTZ), 32'h0);
    chk("midrst_irq", 32'(IRQ), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    PRESETN = 1'b1;
    @(posedge clk); #1;
    chk("postrst_z", 32'(POUTZ), 32'hF);
    apb_read(32'h44, rd, err);
    chk("postrst_ch2_stat", rd, 32'h0);
    apb_read(32'h64, rd, err);
    chk("postrst_ch3_stat", rd, 32'h0);
    apb_read(32'h74, rd, err);
    chk("postrst_ch3_poscnt", rd, 32'h0);
    apb_read(32'h08, rd, err);
    chk("postrst_ch0_period", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
